// File: rtl/bp_resolve_if.sv
// Fetch-push / EX-resolve / counter-update bundle for bp_resolve_queue.
// BP_RESOLVE_STATS_EN adds the branch and mispredict statistic outputs.
interface bp_resolve_if #(parameter int Depth = 4);
  localparam int CW = $clog2(Depth) + 1;

  logic          pred_valid_i;
  logic          pred_ready_o;
  logic [31:0]   pred_pc_i;
  logic          pred_compressed_i;
  logic          pred_taken_i;
  logic [31:0]   pred_target_i;
  logic          ex_res_valid_i;
  logic [31:0]   ex_res_pc_i;
  logic          ex_res_taken_i;
  logic [31:0]   ex_res_target_i;
  logic          flush_i;
  logic          upd_valid_o;
  logic [31:0]   upd_pc_o;
  logic          upd_taken_o;
  logic          mispredict_o;
  logic [31:0]   redirect_pc_o;
  logic          err_o;
  logic [CW-1:0] count_o;
`ifdef BP_RESOLVE_STATS_EN
  logic [31:0]   stat_branches_o;
  logic [31:0]   stat_mispred_o;
`endif

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_compressed_i, pred_taken_i, pred_target_i,
    input  ex_res_valid_i, ex_res_pc_i, ex_res_taken_i, ex_res_target_i, flush_i,
    output pred_ready_o, upd_valid_o, upd_pc_o, upd_taken_o,
`ifdef BP_RESOLVE_STATS_EN
    output stat_branches_o, stat_mispred_o,
`endif
    output mispredict_o, redirect_pc_o, err_o, count_o
  );

  modport master (
    output pred_valid_i, pred_pc_i, pred_compressed_i, pred_taken_i, pred_target_i,
    output ex_res_valid_i, ex_res_pc_i, ex_res_taken_i, ex_res_target_i, flush_i,
    input  pred_ready_o, upd_valid_o, upd_pc_o, upd_taken_o,
`ifdef BP_RESOLVE_STATS_EN
    input  stat_branches_o, stat_mispred_o,
`endif
    input  mispredict_o, redirect_pc_o, err_o, count_o
  );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch predictions checked against EX resolutions; emits
// counter-table updates and redirects. BP_RESOLVE_STATS_EN enables statistics.
module bp_resolve_queue #(
  parameter int Depth = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  bp_resolve_if.slave  bus
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        cmp;
    logic        tk;
    logic [31:0] tgt;
  } entry_t;

  entry_t        mem_q [Depth];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [31:0]   upd_pc_q, upd_pc_d, redirect_q, redirect_d;
  logic          mis_q, mis_d, err_q, err_d;

  entry_t head;
  logic   empty, full, push, res, pc_err, dir_mis, mis, we;

  assign head    = mem_q[rd_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(Depth));
  assign push    = bus.pred_valid_i & ~full;
  assign res     = bus.ex_res_valid_i & ~empty & ~bus.flush_i;
  assign pc_err  = (bus.ex_res_pc_i != head.pc);
  assign dir_mis = (bus.ex_res_taken_i != head.tk) |
                   (bus.ex_res_taken_i & head.tk & (bus.ex_res_target_i != head.tgt));
  assign mis     = res & (dir_mis | pc_err);
  // A mispredict squashes everything younger, including this cycle's push.
  assign we      = push & ~bus.flush_i & ~mis;

  always_comb begin
    wr_d        = wr_q;
    rd_d        = rd_q;
    count_d     = count_q;
    upd_valid_d = 1'b0;
    upd_pc_d    = '0;
    upd_taken_d = 1'b0;
    mis_d       = 1'b0;
    redirect_d  = '0;
    err_d       = 1'b0;
    if (bus.flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else if (mis) begin
      upd_valid_d = 1'b1;
      upd_pc_d    = bus.ex_res_pc_i;
      upd_taken_d = bus.ex_res_taken_i;
      mis_d       = 1'b1;
      redirect_d  = bus.ex_res_taken_i ? bus.ex_res_target_i
                                       : bus.ex_res_pc_i + (head.cmp ? 32'd2 : 32'd4);
      err_d       = pc_err;
      wr_d        = '0;
      rd_d        = '0;
      count_d     = '0;
    end else begin
      if (res) begin
        upd_valid_d = 1'b1;
        upd_pc_d    = bus.ex_res_pc_i;
        upd_taken_d = bus.ex_res_taken_i;
        rd_d        = rd_q + 1'b1;
      end
      if (bus.ex_res_valid_i && empty) err_d = 1'b1;
      if (we) wr_d = wr_q + 1'b1;
      count_d = count_q + CW'(we) - CW'(res);
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_q] <= '{pc: bus.pred_pc_i, cmp: bus.pred_compressed_i,
                             tk: bus.pred_taken_i, tgt: bus.pred_target_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      mis_q       <= 1'b0;
      redirect_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      mis_q       <= mis_d;
      redirect_q  <= redirect_d;
      err_q       <= err_d;
    end
  end

  assign bus.pred_ready_o  = ~full;
  assign bus.count_o       = count_q;
  assign bus.upd_valid_o   = upd_valid_q;
  assign bus.upd_pc_o      = upd_pc_q;
  assign bus.upd_taken_o   = upd_taken_q;
  assign bus.mispredict_o  = mis_q;
  assign bus.redirect_pc_o = redirect_q;
  assign bus.err_o         = err_q;

`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] br_q, mp_q;
  // Counters advance with the pulses they count; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (upd_valid_d && br_q != '1) br_q <= br_q + 1'b1;
      if (mis_d && mp_q != '1)       mp_q <= mp_q + 1'b1;
    end
  end
  assign bus.stat_branches_o = br_q;
  assign bus.stat_mispred_o  = mp_q;
`endif
endmodule

// File: tb/tb_bp_resolve_queue.sv
// Scenario-per-task bench for bp_resolve_queue with an expected-output scoreboard.
module tb_bp_resolve_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_resolve_if #(.Depth(4)) bus();
  bp_resolve_queue #(.Depth(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  typedef struct packed {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        mp;
    logic [31:0] rpc;
    logic        err;
  } out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        cmp;
    logic        tk;
    logic [31:0] tgt;
  } pred_t;

  out_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  function automatic out_t obs();
    return '{bus.upd_valid_o, bus.upd_pc_o, bus.upd_taken_o,
             bus.mispredict_o, bus.redirect_pc_o, bus.err_o};
  endfunction

  task automatic idle_inputs();
    bus.pred_valid_i = 0; bus.pred_pc_i = 0; bus.pred_compressed_i = 0;
    bus.pred_taken_i = 0; bus.pred_target_i = 0;
    bus.ex_res_valid_i = 0; bus.ex_res_pc_i = 0; bus.ex_res_taken_i = 0;
    bus.ex_res_target_i = 0; bus.flush_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic set_push(input logic [31:0] pc, input logic cmp, input logic tk,
                          input logic [31:0] tgt);
    bus.pred_valid_i = 1; bus.pred_pc_i = pc; bus.pred_compressed_i = cmp;
    bus.pred_taken_i = tk; bus.pred_target_i = tgt;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bus.ex_res_valid_i = 1; bus.ex_res_pc_i = pc; bus.ex_res_taken_i = tk;
    bus.ex_res_target_i = tgt;
  endtask

  task automatic expect_out(input out_t e);
    expq.push_back(e);
    if (e.uv) exp_br++;
    if (e.mp) exp_mp++;
  endtask

  task automatic test_reset();
    out_t o;
    rst = 1; tick(); tick();
    tests++; if (bus.count_o !== 3'd0 || bus.pred_ready_o !== 1'b1) begin
      fails++; $display("FAIL reset_count: count=%0d ready=%b want 0/1", bus.count_o, bus.pred_ready_o);
    end
    o = obs();
    tests++; if (o !== '0) begin
      fails++; $display("FAIL reset_outs: got %h want 0", o);
    end
    rst = 0; exp_br = 0; exp_mp = 0;
  endtask

  task automatic test_correct();
    out_t o, e;
    set_push(32'h100, 0, 1, 32'h180); tick();
    tests++; if (bus.count_o !== 3'd1) begin
      fails++; $display("FAIL correct_push_count: got %0d want 1", bus.count_o);
    end
    set_res(32'h100, 1, 32'h180); expect_out('{1, 32'h100, 1, 0, 0, 0}); tick();
    o = obs(); e = expq.pop_front();
    tests++; if (o !== e) begin fails++; $display("FAIL correct_upd: got %h want %h", o, e); end
    tests++; if (bus.count_o !== 3'd0) begin
      fails++; $display("FAIL correct_count: got %0d want 0", bus.count_o);
    end
  endtask

  task automatic test_mispredict();
    out_t o, e;
    set_push(32'h200, 0, 0, 0); tick();
    set_push(32'h210, 0, 0, 0); tick();
    set_push(32'h220, 0, 0, 0); tick();
    tests++; if (bus.count_o !== 3'd3) begin
      fails++; $display("FAIL mis_fill: got %0d want 3", bus.count_o);
    end
    set_res(32'h200, 1, 32'h300); set_push(32'h400, 0, 0, 0);
    expect_out('{1, 32'h200, 1, 1, 32'h300, 0}); tick();
    o = obs(); e = expq.pop_front();
    tests++; if (o !== e) begin fails++; $display("FAIL mis_out: got %h want %h", o, e); end
    tests++; if (bus.count_o !== 3'd0) begin
      fails++; $display("FAIL mis_clear: got %0d want 0", bus.count_o);
    end
    // compressed predicted-taken, resolved not-taken -> fall through by 2
    set_push(32'h50, 1, 1, 32'h80); tick();
    set_res(32'h50, 0, 0); expect_out('{1, 32'h50, 0, 1, 32'h52, 0}); tick();
    o = obs(); e = expq.pop_front();
    tests++; if (o !== e) begin fails++; $display("FAIL mis_compressed: got %h want %h", o, e); end
    // both taken, different target
    set_push(32'h60, 0, 1, 32'h90); tick();
    set_res(32'h60, 1, 32'h94); expect_out('{1, 32'h60, 1, 1, 32'h94, 0}); tick();
    o = obs(); e = expq.pop_front();
    tests++; if (o !== e) begin fails++; $display("FAIL mis_target: got %h want %h", o, e); end
  endtask

  task automatic test_full();
    out_t o, e;
    logic [31:0] pc;
    for (int i = 0; i < 4; i++) begin set_push(32'h10 + 32'(4*i), 0, 0, 0); tick(); end
    tests++; if (bus.count_o !== 3'd4 || bus.pred_ready_o !== 1'b0) begin
      fails++; $display("FAIL full_ready: count=%0d ready=%b want 4/0", bus.count_o, bus.pred_ready_o);
    end
    set_push(32'h77, 0, 0, 0); tick();
    tests++; if (bus.count_o !== 3'd4) begin
      fails++; $display("FAIL full_drop: got %0d want 4", bus.count_o);
    end
    set_push(32'h20, 0, 0, 0); set_res(32'h10, 0, 0);
    expect_out('{1, 32'h10, 0, 0, 0, 0}); tick();
    o = obs(); e = expq.pop_front();
    tests++; if (o !== e) begin fails++; $display("FAIL full_pop: got %h want %h", o, e); end
    tests++; if (bus.count_o !== 3'd3) begin
      fails++; $display("FAIL full_pushpop: got %0d want 3", bus.count_o);
    end
    set_push(32'h20, 0, 0, 0); tick();
    tests++; if (bus.count_o !== 3'd4) begin
      fails++; $display("FAIL full_refill: got %0d want 4", bus.count_o);
    end
    for (int i = 0; i < 4; i++) begin
      pc = 32'h14 + 32'(4*i);
      set_res(pc, 0, 0); expect_out('{1, pc, 0, 0, 0, 0}); tick();
      o = obs(); e = expq.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL full_order%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_errors();
    out_t o, e;
    set_res(32'h100, 0, 0); expect_out('{0, 0, 0, 0, 0, 1}); tick();
    o = obs(); e = expq.pop_front();
    tests++; if (o !== e) begin fails++; $display("FAIL err_empty: got %h want %h", o, e); end
    set_push(32'h100, 0, 0, 0); tick();
    set_push(32'h104, 0, 0, 0); tick();
    set_res(32'h999, 0, 0); expect_out('{1, 32'h999, 0, 1, 32'h99d, 1}); tick();
    o = obs(); e = expq.pop_front();
    tests++; if (o !== e) begin fails++; $display("FAIL err_pc: got %h want %h", o, e); end
    tests++; if (bus.count_o !== 3'd0) begin
      fails++; $display("FAIL err_clear: got %0d want 0", bus.count_o);
    end
  endtask

  task automatic test_flush();
    out_t o;
    set_push(32'h100, 0, 0, 0); tick();
    set_push(32'h104, 0, 0, 0); tick();
    set_push(32'h108, 0, 0, 0); set_res(32'h100, 0, 0); bus.flush_i = 1; tick();
    o = obs();
    tests++; if (o !== '0) begin fails++; $display("FAIL flush_outs: got %h want 0", o); end
    tests++; if (bus.count_o !== 3'd0) begin
      fails++; $display("FAIL flush_count: got %0d want 0", bus.count_o);
    end
    tick();
`ifdef BP_RESOLVE_STATS_EN
    tests++; if (bus.stat_branches_o !== 32'(exp_br) || bus.stat_mispred_o !== 32'(exp_mp)) begin
      fails++; $display("FAIL flush_stats: got %0d/%0d want %0d/%0d",
                        bus.stat_branches_o, bus.stat_mispred_o, exp_br, exp_mp);
    end
`endif
  endtask

  task automatic test_back_to_back();
    pred_t pq[$];
    pred_t h;
    out_t  o, e;
    logic  pv, rv, flip, acc, atk;
    logic [31:0] npc = 32'h1000, rpc;
    for (int c = 0; c < 120; c++) begin
      pv = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 2) != 0);
      flip = ($urandom_range(0, 7) == 0);
      acc = pv && (pq.size() < 4);
      if (pv) set_push(npc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), npc + 32'h40);
      if (rv && pq.size() == 0) begin
        set_res(32'h5000, 0, 0); expect_out('{0, 0, 0, 0, 0, 1});
      end else if (rv) begin
        h = pq[0];
        atk = flip ? ~h.tk : h.tk;
        set_res(h.pc, atk, h.tgt);
        rpc = atk ? h.tgt : h.pc + (h.cmp ? 32'd2 : 32'd4);
        expect_out('{1, h.pc, atk, flip, flip ? rpc : 32'd0, 0});
      end else expect_out('0);
      if (rv && pq.size() != 0 && flip) pq.delete();
      else begin
        if (rv && pq.size() != 0) void'(pq.pop_front());
        if (acc) pq.push_back('{npc, bus.pred_compressed_i, bus.pred_taken_i, npc + 32'h40});
      end
      if (acc) npc = npc + 32'h10;
      tick();
      o = obs(); e = expq.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL b2b_out c%0d: got %h want %h", c, o, e); end
      tests++; if (bus.count_o !== 3'(pq.size())) begin
        fails++; $display("FAIL b2b_count c%0d: got %0d want %0d", c, bus.count_o, pq.size());
      end
    end
    while (pq.size() != 0) begin
      h = pq.pop_front();
      set_res(h.pc, h.tk, h.tgt); expect_out('{1, h.pc, h.tk, 0, 0, 0}); tick();
      o = obs(); e = expq.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL b2b_drain: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    set_push(32'h700, 0, 0, 0); tick();
    set_push(32'h704, 0, 0, 0); tick();
    rst = 1; set_push(32'h708, 0, 0, 0); set_res(32'h700, 1, 32'h0); tick();
    rst = 0; exp_br = 0; exp_mp = 0;
    tests++; if (bus.count_o !== 3'd0 || obs() !== '0) begin
      fails++; $display("FAIL reset_mid: count=%0d outs=%h want 0/0", bus.count_o, obs());
    end
`ifdef BP_RESOLVE_STATS_EN
    tests++; if (bus.stat_branches_o !== 32'd0 || bus.stat_mispred_o !== 32'd0) begin
      fails++; $display("FAIL reset_stats: got %0d/%0d want 0/0", bus.stat_branches_o, bus.stat_mispred_o);
    end
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_errors();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    tests++; if (expq.size() != 0) begin
      fails++; $display("FAIL scoreboard_leftover: got %0d want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
